// File: rtl/video_timer_gen.sv
// Parametrised raster timer: sync/blank generation, pixel-load strobe and framebuffer
// address, with phase-lock status, tear-free page select and a vertical-blank interrupt.
module video_timer_gen #(
    parameter int unsigned H_VISIBLE     = 128,
    parameter int unsigned H_TOTAL       = 168,
    parameter int unsigned H_SYNC_START  = 131,
    parameter int unsigned H_SYNC_END    = 147,
    parameter int unsigned V_VIS_START   = 42,
    parameter int unsigned V_VIS_END     = 725,
    parameter int unsigned V_TOTAL       = 806,
    parameter int unsigned V_SYNC_START  = 771,
    parameter int unsigned V_SYNC_END    = 776,
    parameter int unsigned PIXEL_LATENCY = 1,
    parameter int unsigned LINE_REPEAT   = 2,
    parameter int unsigned ADDR_W        = 22,
    parameter logic [ADDR_W-1:0] SCREEN_BASE = 22'h3FA700,
    parameter logic [ADDR_W-1:0] ALT_OFFSET  = 22'h8000
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              clk_en,
    input  logic [1:0]        busCycle,
    input  logic              vid_alt,
    output logic [ADDR_W-1:0] videoAddr,
    output logic              hsync,
    output logic              vsync,
    output logic              _hblank,
    output logic              _vblank,
    output logic              loadPixels,
    output logic              locked,
    output logic              vblank_irq
);

    localparam int unsigned XW = $clog2(H_TOTAL);
    localparam int unsigned YW = $clog2(V_TOTAL);
    localparam int unsigned RW = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;

    localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_HS_START = XW'(H_SYNC_START + PIXEL_LATENCY);
    localparam logic [XW-1:0] X_HS_END   = XW'(H_SYNC_END + PIXEL_LATENCY);
    localparam logic [XW-1:0] X_HB_START = XW'(H_VISIBLE + PIXEL_LATENCY);

    localparam logic [YW-1:0] Y_LAST      = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_VIS_START = YW'(V_VIS_START);
    localparam logic [YW-1:0] Y_VIS_END   = YW'(V_VIS_END);
    localparam logic [YW-1:0] Y_VS_START  = YW'(V_SYNC_START);
    localparam logic [YW-1:0] Y_VS_END    = YW'(V_SYNC_END);

    localparam logic [RW-1:0]     R_LAST    = RW'(LINE_REPEAT - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_VISIBLE / 2);

    logic [XW-1:0]     xpos;
    logic [YW-1:0]     ypos;
    logic              page_sel;
    logic [ADDR_W-1:0] line_base;
    logic [RW-1:0]     rep_cnt;

    logic              endline;
    logic              frame_end;
    logic              vis_line;
    logic              x_hold;
    logic [ADDR_W-1:0] word_off;

    // Raster position decode; xpos waits at 0 until the bus sequencer is at phase 0.
    always_comb begin
        endline   = (xpos == X_LAST);
        frame_end = endline && (ypos == Y_LAST);
        vis_line  = (ypos >= Y_VIS_START) && (ypos <= Y_VIS_END);
        x_hold    = (xpos == '0) && (busCycle != 2'd0);
        word_off  = ADDR_W'({xpos[XW-1:2], 1'b0});
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            xpos       <= '0;
            ypos       <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            locked     <= 1'b0;
            vblank_irq <= 1'b0;
            page_sel   <= 1'b0;
            line_base  <= '0;
            rep_cnt    <= '0;
        end else begin
            // Interrupt is a single clk wide regardless of clk_en duty cycle.
            vblank_irq <= clk_en && endline && (ypos == Y_VIS_END);
            if (clk_en) begin
                hsync <= !((xpos >= X_HS_START) && (xpos <= X_HS_END));
                vsync <= !((ypos >= Y_VS_START) && (ypos <= Y_VS_END));
                if (endline) begin
                    xpos <= '0;
                end else if (!x_hold) begin
                    xpos <= xpos + XW'(1);
                end
                if ((xpos == '0) && !x_hold) begin
                    locked <= 1'b1;
                end
                if (endline) begin
                    ypos <= frame_end ? '0 : ypos + YW'(1);
                    // Page and row base only move at the frame wrap, so no tearing.
                    if (frame_end) begin
                        page_sel  <= vid_alt;
                        line_base <= '0;
                        rep_cnt   <= '0;
                    end else if (vis_line) begin
                        if (rep_cnt == R_LAST) begin
                            rep_cnt   <= '0;
                            line_base <= line_base + LINE_STEP;
                        end else begin
                            rep_cnt <= rep_cnt + RW'(1);
                        end
                    end
                end
            end
        end
    end

    // Blanking, load strobe and address are decoded directly from the counters.
    always_comb begin
        _hblank    = (xpos < X_HB_START);
        _vblank    = vis_line;
        loadPixels = _hblank && _vblank && (busCycle == 2'd0);
        videoAddr  = SCREEN_BASE - (page_sel ? '0 : ALT_OFFSET) + line_base + word_off;
    end

endmodule

// File: tb/tb_video_timer_gen.sv
// Bench for video_timer_gen: two instances (line repeat 2 and 1) on a short raster,
// checked against a slot-count reference model, a vector table and directed sequences.
module tb_video_timer_gen;

    localparam int HV  = 128;
    localparam int HT  = 168;
    localparam int HSS = 131;
    localparam int HSE = 147;
    localparam int VVS = 4;
    localparam int VVE = 11;
    localparam int VT  = 20;
    localparam int VSS = 14;
    localparam int VSE = 15;
    localparam int PL  = 1;
    localparam int SB  = 32'h3FA700;
    localparam int ALT = 32'h8000;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic [1:0]  busCycle;
    logic        vid_alt;

    logic [21:0] addr_a, addr_b;
    logic        hs_a, vs_a, hb_a, vb_a, ld_a, lk_a, irq_a;
    logic        hs_b, vs_b, hb_b, vb_b, ld_b, lk_b, irq_b;

    video_timer_gen #(
        .H_VISIBLE(HV), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_VIS_START(VVS), .V_VIS_END(VVE), .V_TOTAL(VT),
        .V_SYNC_START(VSS), .V_SYNC_END(VSE), .PIXEL_LATENCY(PL),
        .LINE_REPEAT(2), .ADDR_W(22),
        .SCREEN_BASE(22'h3FA700), .ALT_OFFSET(22'h8000)
    ) dut_a (
        .clk(clk), ._reset(rst_n), .clk_en(clk_en), .busCycle(busCycle), .vid_alt(vid_alt),
        .videoAddr(addr_a), .hsync(hs_a), .vsync(vs_a), ._hblank(hb_a), ._vblank(vb_a),
        .loadPixels(ld_a), .locked(lk_a), .vblank_irq(irq_a)
    );

    video_timer_gen #(
        .H_VISIBLE(HV), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_VIS_START(VVS), .V_VIS_END(VVE), .V_TOTAL(VT),
        .V_SYNC_START(VSS), .V_SYNC_END(VSE), .PIXEL_LATENCY(PL),
        .LINE_REPEAT(1), .ADDR_W(22),
        .SCREEN_BASE(22'h3FA700), .ALT_OFFSET(22'h8000)
    ) dut_b (
        .clk(clk), ._reset(rst_n), .clk_en(clk_en), .busCycle(busCycle), .vid_alt(vid_alt),
        .videoAddr(addr_b), .hsync(hs_b), .vsync(vs_b), ._hblank(hb_b), ._vblank(vb_b),
        .loadPixels(ld_b), .locked(lk_b), .vblank_irq(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: p counts slots advanced since reset; raster position is p mod geometry.
    int   p;
    logic m_hs, m_vs, m_irq, m_lock, m_page;
    logic [1:0] bcnt;
    int   hs_low, hs_first, irq_seen_a, irq_seen_b;

    typedef struct {
        int          y;
        int          x;
        logic [31:0] addr_a;
        logic [31:0] addr_b;
        logic        hb;
        logic        vb;
    } vec_t;
    vec_t tbl [9];

    function automatic int cur_x();
        return p % HT;
    endfunction

    function automatic int cur_y();
        return (p / HT) % VT;
    endfunction

    function automatic int exp_base(input int lr, input int y);
        if (y < VVS)  return 0;
        if (y <= VVE) return ((y - VVS) / lr) * (HV / 2);
        return ((VVE - VVS + 1) / lr) * (HV / 2);
    endfunction

    function automatic logic [31:0] exp_addr(input int lr);
        int a;
        a = SB - (m_page ? 0 : ALT) + exp_base(lr, cur_y()) + (cur_x() / 4) * 2;
        return 32'(a & 32'h3FFFFF);
    endfunction

    task automatic model_reset();
        p = 0; m_hs = 1'b1; m_vs = 1'b1; m_irq = 1'b0; m_lock = 1'b0; m_page = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [1:0] bc, input logic alt);
        int x, y;
        x = cur_x();
        y = cur_y();
        m_irq = en && (x == HT - 1) && (y == VVE);
        if (en) begin
            m_hs = !((x >= HSS + PL) && (x <= HSE + PL));
            m_vs = !((y >= VSS) && (y <= VSE));
            if ((x == HT - 1) && (y == VT - 1)) m_page = alt;
            if (!((x == 0) && (bc != 2'd0))) begin
                if (x == 0) m_lock = 1'b1;
                p = p + 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t y=%0d x=%0d)",
                     name, act, exp, $time, cur_y(), cur_x());
        end
    endtask

    task automatic check_all();
        logic hb, vb, ld;
        hb = (cur_x() < HV + PL);
        vb = (cur_y() >= VVS) && (cur_y() <= VVE);
        ld = hb && vb && (busCycle == 2'd0);
        chk("videoAddr_rep2", 32'(addr_a), exp_addr(2));
        chk("videoAddr_rep1", 32'(addr_b), exp_addr(1));
        chk("hsync",      32'(hs_a),  32'(m_hs));
        chk("vsync",      32'(vs_a),  32'(m_vs));
        chk("hblank_n",   32'(hb_a),  32'(hb));
        chk("vblank_n",   32'(vb_a),  32'(vb));
        chk("loadPixels", 32'(ld_a),  32'(ld));
        chk("locked",     32'(lk_a),  32'(m_lock));
        chk("vblank_irq", 32'(irq_a), 32'(m_irq));
        chk("hsync_b",    32'(hs_b),  32'(m_hs));
        chk("vsync_b",    32'(vs_b),  32'(m_vs));
        chk("loadPixels_b", 32'(ld_b), 32'(ld));
        chk("vblank_irq_b", 32'(irq_b), 32'(m_irq));
        if (!hs_a) begin
            if (hs_low == 0) hs_first = cur_x();
            hs_low++;
        end
        if (irq_a) irq_seen_a++;
        if (irq_b) irq_seen_b++;
    endtask

    // One clk: drive, check at negedge, advance the model at the posedge.
    task automatic cycle(input logic en, input logic [1:0] bc, input logic alt);
        clk_en = en; busCycle = bc; vid_alt = alt;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step(en, bc, alt);
        #1;
    endtask

    task automatic goto(input int ty, input int tx, input logic alt);
        int  n;
        bit  hit;
        n = 0;
        hit = 0;
        while (!hit && n < 3 * HT * VT) begin
            cycle(1'b1, bcnt, alt);
            bcnt = bcnt + 2'd1;
            n++;
            hit = (cur_x() == tx) && (cur_y() == ty);
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL goto_timeout: position (%0d,%0d) not reached, required (%0d,%0d)",
                     cur_y(), cur_x(), ty, tx);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ralt;
        tbl[0] = '{4,   0, 32'h3FA700, 32'h3FA700, 1'b1, 1'b1};
        tbl[1] = '{4,   8, 32'h3FA704, 32'h3FA704, 1'b1, 1'b1};
        tbl[2] = '{5,   0, 32'h3FA700, 32'h3FA740, 1'b1, 1'b1};
        tbl[3] = '{5, 127, 32'h3FA73E, 32'h3FA77E, 1'b1, 1'b1};
        tbl[4] = '{5, 129, 32'h3FA740, 32'h3FA780, 1'b0, 1'b1};
        tbl[5] = '{6,   0, 32'h3FA740, 32'h3FA780, 1'b1, 1'b1};
        tbl[6] = '{11,  0, 32'h3FA7C0, 32'h3FA8C0, 1'b1, 1'b1};
        tbl[7] = '{12,  0, 32'h3FA800, 32'h3FA900, 1'b1, 1'b0};
        tbl[8] = '{19, 167, 32'h3FA852, 32'h3FA952, 1'b0, 1'b0};

        hs_low = 0; hs_first = 0; irq_seen_a = 0; irq_seen_b = 0;
        rst_n = 1'b0; clk_en = 1'b0; busCycle = 2'd2; vid_alt = 1'b0;
        model_reset();
        #12;
        chk("rst_hsync",  32'(hs_a),   32'd1);
        chk("rst_vsync",  32'(vs_a),   32'd1);
        chk("rst_locked", 32'(lk_a),   32'd0);
        chk("rst_irq",    32'(irq_a),  32'd0);
        chk("rst_addr",   32'(addr_a), 32'h3F2700);
        chk("rst_vblank_n", 32'(vb_a), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Startup alignment: busCycle 2,3 hold xpos at 0; lock on the first 0->1 step.
        cycle(1'b1, 2'd2, 1'b0);
        cycle(1'b1, 2'd3, 1'b0);
        chk("lock_wait",   32'(lk_a),   32'd0);
        chk("hold_addr",   32'(addr_a), 32'h3F2700);
        cycle(1'b1, 2'd0, 1'b0);
        chk("lock_rise",   32'(lk_a),   32'd1);
        bcnt = 2'd1;

        // Vector table, page 1 latched at the preceding frame wrap.
        goto(0, 0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            goto(tbl[i].y, tbl[i].x, 1'b1);
            clk_en = 1'b0; busCycle = bcnt; vid_alt = 1'b1;
            @(negedge clk);
            check_all();
            chk($sformatf("tbl%0d_addr_rep2", i), 32'(addr_a), tbl[i].addr_a);
            chk($sformatf("tbl%0d_addr_rep1", i), 32'(addr_b), tbl[i].addr_b);
            chk($sformatf("tbl%0d_hblank_n", i),  32'(hb_a),   32'(tbl[i].hb));
            chk($sformatf("tbl%0d_vblank_n", i),  32'(vb_a),   32'(tbl[i].vb));
            @(posedge clk);
            model_step(1'b0, bcnt, 1'b1);
            #1;
        end

        // Page request mid-frame takes effect only after the wrap.
        goto(8, 0, 1'b1);
        goto(9, 0, 1'b0);
        chk("page_hold_rep2", 32'(addr_a), 32'h3FA780);
        chk("page_hold_rep1", 32'(addr_b), 32'h3FA840);
        goto(4, 0, 1'b0);
        chk("page0_rep2", 32'(addr_a), 32'h3F2700);
        chk("page0_rep1", 32'(addr_b), 32'h3F2700);

        // hsync low window over one line: registered from xpos 132..148.
        goto(2, 0, 1'b1);
        hs_low = 0;
        goto(3, 0, 1'b1);
        chk("hsync_low_slots", 32'(hs_low),   32'd17);
        chk("hsync_first_x",   32'(hs_first), 32'd133);

        // Exactly one vblank interrupt per frame in both instances.
        goto(0, 0, 1'b1);
        irq_seen_a = 0; irq_seen_b = 0;
        goto(0, 0, 1'b1);
        chk("irq_per_frame_rep2", 32'(irq_seen_a), 32'd1);
        chk("irq_per_frame_rep1", 32'(irq_seen_b), 32'd1);

        // clk_en low for 10 clks mid-line freezes everything.
        goto(3, 50, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 2'($urandom), 1'($urandom));
        chk("freeze_addr",  32'(addr_a), 32'h3FA718);
        chk("freeze_hsync", 32'(hs_a),   32'd1);

        // Asynchronous reset in the middle of an hsync/vsync pulse.
        goto(14, 140, 1'b1);
        chk("pre_rst_hsync", 32'(hs_a), 32'd0);
        chk("pre_rst_vsync", 32'(vs_a), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_hsync",  32'(hs_a),   32'd1);
        chk("mid_rst_vsync",  32'(vs_a),   32'd1);
        chk("mid_rst_locked", 32'(lk_a),   32'd0);
        chk("mid_rst_addr",   32'(addr_a), 32'h3F2700);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bcnt = 2'd3;
        cycle(1'b1, bcnt, 1'b0);
        chk("relock_wait", 32'(lk_a), 32'd0);
        bcnt = 2'd0;
        goto(0, 5, 1'b1);
        chk("relock", 32'(lk_a), 32'd1);

        // Randomised run: gapped clk_en, occasional bus phase slips and page requests.
        ralt = 1'b1;
        for (int i = 0; i < 17000; i++) begin
            logic en;
            en = ($urandom % 10) != 0;
            if (($urandom % 8) == 0) bcnt = 2'($urandom);
            if (($urandom % 400) == 0) ralt = ~ralt;
            cycle(en, bcnt, ralt);
            if (en) bcnt = bcnt + 2'd1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
